pic_command_sequencer: RTL and testbench
========================================

PIC_COMMAND_SEQUENCER -- requirements
Module: pic_command_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on chip_select_n, read_enable_n, write_enable_n and address; legal range 2..4.
REQ-002 Parameter CASCADE_EN, default 1; 0 means ICW3 is never expected, whatever ICW1.SNGL says.
REQ-003 Parameter ICW4_EN, default 1; 0 means ICW4 is never expected, whatever ICW1.IC4 says.
REQ-004 clock  input  1  single system clock; all state is on its rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clock.
REQ-006 chip_select_n  input  1  bus chip select, active low, asynchronous to clock.
REQ-007 read_enable_n  input  1  bus read strobe, active low, asynchronous.
REQ-008 write_enable_n  input  1  bus write strobe, active low, asynchronous.
REQ-009 address  input  1  bus A0, asynchronous.
REQ-010 data_bus_in  input  8  bus write data; stable while write_enable_n is low.
REQ-011 internal_data_bus  output  8  last captured write byte.
REQ-012 write_initial_command_word_1 / _2 / _3 / _4  output  1 each  one-cycle ICW strobes.
REQ-013 write_operation_control_word_1 / _2 / _3  output  1 each  one-cycle OCW strobes.
REQ-014 read  output  1  level: synchronized CS and RD both active.
REQ-015 read_start  output  1  one-cycle pulse on the first cycle of read.
REQ-016 init_done  output  1  high in state READY.
REQ-017 cascade_mode  output  1  latched ~ICW1.D1 AND CASCADE_EN.
REQ-018 sequence_error  output  1  one-cycle pulse when a write is ignored.

Function
REQ-019 All four bus control inputs SHALL pass through SYNC_STAGES flops before use; a captured write byte SHALL be registered in the cycle its strobe is asserted.
REQ-020 While synchronized CS and WR are both low, data_bus_in SHALL be sampled every cycle into a shadow register. The value sampled on the last low cycle is used.
REQ-021 A write event SHALL occur in the cycle after synchronized WR rises 0->1, provided synchronized CS was low in the cycle before the rise. A rise with CS high is no event.
REQ-022 On a write event, the shadow byte and the synchronized A0 latched with it SHALL be decoded. Exactly one strobe or sequence_error SHALL pulse for exactly one cycle, and internal_data_bus SHALL take the shadow byte in that same cycle.
REQ-023 States: WAIT_ICW1, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
REQ-024 A0=0 with D4=1 in any state SHALL pulse ICW1 and latch SNGL=D1 and IC4=D0, then go to WAIT_ICW2. This includes a mid-sequence or READY restart.
REQ-025 In WAIT_ICW2, A0=1 SHALL pulse ICW2. The next state is WAIT_ICW3 if the cascade is needed (~SNGL & CASCADE_EN), else WAIT_ICW4 if IC4 & ICW4_EN, else READY.
REQ-026 In WAIT_ICW3, A0=1 SHALL pulse ICW3. The next state is WAIT_ICW4 if IC4 & ICW4_EN, else READY.
REQ-027 In WAIT_ICW4, A0=1 SHALL pulse ICW4 and go to READY.
REQ-028 In READY:
- A0=1 pulses OCW1.
- A0=0, D4=0, D3=0 pulses OCW2.
- A0=0, D4=0, D3=1 pulses OCW3.
- The state is unchanged in all three cases.
REQ-029 Any A0=0, D4=0 write outside READY SHALL be ignored and pulse sequence_error; the state and latched bits are unchanged.
REQ-030 read_start SHALL pulse in the first cycle read goes high. Writes and reads are independent, and a simultaneous read and write event SHALL both be honoured.

Reset
REQ-031 reset_n low SHALL immediately force the following:
- state to WAIT_ICW1;
- all strobes, read, read_start, init_done, cascade_mode and sequence_error to 0;
- internal_data_bus and the shadow register to 8'h00;
- all synchronizer flops to 1 for active-low controls and 0 for A0.
REQ-032 Reset asserted during a bus write SHALL discard it; no strobe is issued after release until a new complete write occurs.

Structure
REQ-033 A shared package pic_pkg SHALL hold the state enumeration and the bit-position constants: IC4=0, SNGL=1, D3 select=3, D4 select=4.
REQ-034 A single sub-module pic_sync_edge SHALL provide one SYNC_STAGES-deep synchronizer with registered rise and fall pulses. It is instantiated once per control input.

Verification
REQ-035 Write A0=0 8'h13 then A0=1 8'h20 then A0=1 8'h01 -> ICW1, ICW2 and ICW4 pulse once each, ICW3 never, init_done=1, cascade_mode=0.
REQ-036 Write 8'h11, 8'h20, 8'h04, 8'h01 with CASCADE_EN=1 -> ICW1 through ICW4 in order, cascade_mode=1; the same stimulus with CASCADE_EN=0 -> ICW3 skipped and 8'h04 taken as ICW4.
REQ-037 In READY, write A0=1 8'hFB, A0=0 8'h20, A0=0 8'h0B -> OCW1, OCW2 and OCW3 each pulse one cycle, and internal_data_bus shows FB, 20, 0B.
REQ-038 Write A0=0 8'h20 before initialization -> sequence_error pulses and the state stays WAIT_ICW1; ICW1 8'h13 issued in READY -> the state returns to WAIT_ICW2 with init_done=0.
REQ-039 Write pulse with chip_select_n high -> no strobe; reset_n pulsed mid-write -> all outputs 0 immediately and no strobe after release.
REQ-040 Hold CS and RD low for 5 cycles -> read is high 5 cycles after the sync latency, and read_start pulses exactly once.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC command sequencer.
package pic_pkg;

  // Initialization / operating states of the command sequencer.
  typedef enum logic [2:0] {
    StWaitIcw1,
    StWaitIcw2,
    StWaitIcw3,
    StWaitIcw4,
    StReady
  } pic_state_e;

  // Bit positions inside a written command byte.
  localparam int unsigned BitIc4   = 0;
  localparam int unsigned BitSngl  = 1;
  localparam int unsigned BitD3Sel = 3;
  localparam int unsigned BitD4Sel = 4;

  // Positions of the one-cycle outcome pulses in the strobe vector.
  localparam int unsigned EvIcw1   = 0;
  localparam int unsigned EvIcw2   = 1;
  localparam int unsigned EvIcw3   = 2;
  localparam int unsigned EvIcw4   = 3;
  localparam int unsigned EvOcw1   = 4;
  localparam int unsigned EvOcw2   = 5;
  localparam int unsigned EvOcw3   = 6;
  localparam int unsigned EvSeqErr = 7;
  localparam int unsigned NumEv    = 8;

  // State that follows ICW2, given the bits latched from ICW1.
  function automatic pic_state_e pic_next_after_icw2(input logic sngl, input logic ic4,
                                                     input logic cascade_en,
                                                     input logic icw4_en);
    if (!sngl && cascade_en) begin
      return StWaitIcw3;
    end
    if (ic4 && icw4_en) begin
      return StWaitIcw4;
    end
    return StReady;
  endfunction

endpackage

// File: rtl/pic_sync_edge.sv
// Multi-flop synchronizer for one asynchronous bus control bit, with registered
// rise/fall pulses that appear one cycle after the synchronized level changes.
module pic_sync_edge #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] chain_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  // Shift the raw input through the chain and detect edges on the last stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= {Stages{ResetVal}};
      prev_q  <= ResetVal;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[Stages-2:0], async_i};
      prev_q  <= chain_q[Stages-1];
      rise_q  <= chain_q[Stages-1] & ~prev_q;
      fall_q  <= ~chain_q[Stages-1] & prev_q;
    end
  end

  assign level_o = chain_q[Stages-1];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/pic_command_sequencer.sv
// Bus-facing command sequencer of an 8259-style PIC: synchronizes the bus strobes,
// captures written bytes and steps through the ICW1..ICW4 initialization sequence
// before decoding OCW1..OCW3 in the ready state.
module pic_command_sequencer
  import pic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,  // legal range 2..4
  parameter bit          CASCADE_EN  = 1'b1,
  parameter bit          ICW4_EN     = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       chip_select_n,
  input  logic       read_enable_n,
  input  logic       write_enable_n,
  input  logic       address,
  input  logic [7:0] data_bus_in,
  output logic [7:0] internal_data_bus,
  output logic       write_initial_command_word_1,
  output logic       write_initial_command_word_2,
  output logic       write_initial_command_word_3,
  output logic       write_initial_command_word_4,
  output logic       write_operation_control_word_1,
  output logic       write_operation_control_word_2,
  output logic       write_operation_control_word_3,
  output logic       read,
  output logic       read_start,
  output logic       init_done,
  output logic       cascade_mode,
  output logic       sequence_error
);

  logic cs_s, rd_s, wr_s, a0_s;
  logic wr_rise;
  logic cs_rise_unused, cs_fall_unused, rd_rise_unused, rd_fall_unused;
  logic wr_fall_unused, a0_rise_unused, a0_fall_unused;

  pic_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_cs (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .async_i (chip_select_n),
    .level_o (cs_s),
    .rise_o  (cs_rise_unused),
    .fall_o  (cs_fall_unused)
  );

  pic_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_rd (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .async_i (read_enable_n),
    .level_o (rd_s),
    .rise_o  (rd_rise_unused),
    .fall_o  (rd_fall_unused)
  );

  pic_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_wr (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .async_i (write_enable_n),
    .level_o (wr_s),
    .rise_o  (wr_rise),
    .fall_o  (wr_fall_unused)
  );

  pic_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_a0 (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .async_i (address),
    .level_o (a0_s),
    .rise_o  (a0_rise_unused),
    .fall_o  (a0_fall_unused)
  );

  // ---------------------------------------------------------------------------
  // Write capture
  // ---------------------------------------------------------------------------
  logic [7:0] shadow_q;
  logic       shadow_a0_q;
  logic       cs_prev_q;   // synchronized CS one cycle back
  logic       wr_cs_ok_q;  // CS was low in the cycle before the WR rise
  logic       write_event;

  // Sample the bus on every selected write cycle; the last sample wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q    <= 8'h00;
      shadow_a0_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      wr_cs_ok_q  <= 1'b0;
    end else begin
      if (!cs_s && !wr_s) begin
        shadow_q    <= data_bus_in;
        shadow_a0_q <= a0_s;
      end
      cs_prev_q  <= cs_s;
      wr_cs_ok_q <= ~cs_prev_q;
    end
  end

  // wr_rise is registered one cycle after the synchronized rise, so wr_cs_ok_q
  // lines up with CS as seen in the cycle before that rise.
  assign write_event = wr_rise & wr_cs_ok_q;

  // ---------------------------------------------------------------------------
  // Command decode and sequencing
  // ---------------------------------------------------------------------------
  pic_state_e       state_q, state_d;
  logic             sngl_q, sngl_d;
  logic             ic4_q, ic4_d;
  logic             cascade_q, cascade_d;
  logic [NumEv-1:0] strb_q, strb_d;
  logic [7:0]       data_q, data_d;
  logic             init_done_q;

  // Decode a completed write against the current state into one outcome pulse.
  always_comb begin
    state_d   = state_q;
    sngl_d    = sngl_q;
    ic4_d     = ic4_q;
    cascade_d = cascade_q;
    strb_d    = '0;
    data_d    = data_q;
    if (write_event) begin
      data_d = shadow_q;
      if (!shadow_a0_q && shadow_q[BitD4Sel]) begin
        // ICW1 restarts initialization from any state.
        strb_d[EvIcw1] = 1'b1;
        sngl_d         = shadow_q[BitSngl];
        ic4_d          = shadow_q[BitIc4];
        cascade_d      = ~shadow_q[BitSngl] & CASCADE_EN;
        state_d        = StWaitIcw2;
      end else if (!shadow_a0_q) begin
        if (state_q == StReady) begin
          if (shadow_q[BitD3Sel]) begin
            strb_d[EvOcw3] = 1'b1;
          end else begin
            strb_d[EvOcw2] = 1'b1;
          end
        end else begin
          strb_d[EvSeqErr] = 1'b1;
        end
      end else begin
        case (state_q)
          StWaitIcw2: begin
            strb_d[EvIcw2] = 1'b1;
            state_d        = pic_next_after_icw2(sngl_q, ic4_q, CASCADE_EN, ICW4_EN);
          end
          StWaitIcw3: begin
            strb_d[EvIcw3] = 1'b1;
            state_d        = (ic4_q && ICW4_EN) ? StWaitIcw4 : StReady;
          end
          StWaitIcw4: begin
            strb_d[EvIcw4] = 1'b1;
            state_d        = StReady;
          end
          StReady: begin
            strb_d[EvOcw1] = 1'b1;
          end
          default: begin
            // A0=1 before ICW1 has nothing to program.
            strb_d[EvSeqErr] = 1'b1;
          end
        endcase
      end
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StWaitIcw1;
      sngl_q      <= 1'b0;
      ic4_q       <= 1'b0;
      cascade_q   <= 1'b0;
      strb_q      <= '0;
      data_q      <= 8'h00;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sngl_q      <= sngl_d;
      ic4_q       <= ic4_d;
      cascade_q   <= cascade_d;
      strb_q      <= strb_d;
      data_q      <= data_d;
      init_done_q <= (state_d == StReady);
    end
  end

  // ---------------------------------------------------------------------------
  // Read path, independent of the write sequencer
  // ---------------------------------------------------------------------------
  logic read_q;
  logic read_start_q;

  // Registered read level and its first-cycle pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_q       <= 1'b0;
      read_start_q <= 1'b0;
    end else begin
      read_q       <= ~cs_s & ~rd_s;
      read_start_q <= ~cs_s & ~rd_s & ~read_q;
    end
  end

  assign internal_data_bus              = data_q;
  assign write_initial_command_word_1   = strb_q[EvIcw1];
  assign write_initial_command_word_2   = strb_q[EvIcw2];
  assign write_initial_command_word_3   = strb_q[EvIcw3];
  assign write_initial_command_word_4   = strb_q[EvIcw4];
  assign write_operation_control_word_1 = strb_q[EvOcw1];
  assign write_operation_control_word_2 = strb_q[EvOcw2];
  assign write_operation_control_word_3 = strb_q[EvOcw3];
  assign sequence_error                 = strb_q[EvSeqErr];
  assign read                           = read_q;
  assign read_start                     = read_start_q;
  assign init_done                      = init_done_q;
  assign cascade_mode                   = cascade_q;

endmodule

// File: tb/tb_pic_command_sequencer.sv
// Directed bench: DUT0 uses the defaults, DUT1 has CASCADE_EN=0; both share stimulus.
module tb_pic_command_sequencer;

  logic       clock;
  logic       reset_n;
  logic       chip_select_n;
  logic       read_enable_n;
  logic       write_enable_n;
  logic       address;
  logic [7:0] data_bus_in;

  logic [7:0] idb0, idb1;
  logic       icw1_0, icw2_0, icw3_0, icw4_0, ocw1_0, ocw2_0, ocw3_0, err0;
  logic       icw1_1, icw2_1, icw3_1, icw4_1, ocw1_1, ocw2_1, ocw3_1, err1;
  logic       read0, read1, rstart0, rstart1, init0, init1, casc0, casc1;
  logic [7:0] ev0, ev1;

  int n_checks = 0;
  int n_fail   = 0;

  pic_command_sequencer u_dut0 (
    .clock                          (clock),
    .reset_n                        (reset_n),
    .chip_select_n                  (chip_select_n),
    .read_enable_n                  (read_enable_n),
    .write_enable_n                 (write_enable_n),
    .address                        (address),
    .data_bus_in                    (data_bus_in),
    .internal_data_bus              (idb0),
    .write_initial_command_word_1   (icw1_0),
    .write_initial_command_word_2   (icw2_0),
    .write_initial_command_word_3   (icw3_0),
    .write_initial_command_word_4   (icw4_0),
    .write_operation_control_word_1 (ocw1_0),
    .write_operation_control_word_2 (ocw2_0),
    .write_operation_control_word_3 (ocw3_0),
    .read                           (read0),
    .read_start                     (rstart0),
    .init_done                      (init0),
    .cascade_mode                   (casc0),
    .sequence_error                 (err0)
  );

  pic_command_sequencer #(.CASCADE_EN(1'b0)) u_dut1 (
    .clock                          (clock),
    .reset_n                        (reset_n),
    .chip_select_n                  (chip_select_n),
    .read_enable_n                  (read_enable_n),
    .write_enable_n                 (write_enable_n),
    .address                        (address),
    .data_bus_in                    (data_bus_in),
    .internal_data_bus              (idb1),
    .write_initial_command_word_1   (icw1_1),
    .write_initial_command_word_2   (icw2_1),
    .write_initial_command_word_3   (icw3_1),
    .write_initial_command_word_4   (icw4_1),
    .write_operation_control_word_1 (ocw1_1),
    .write_operation_control_word_2 (ocw2_1),
    .write_operation_control_word_3 (ocw3_1),
    .read                           (read1),
    .read_start                     (rstart1),
    .init_done                      (init1),
    .cascade_mode                   (casc1),
    .sequence_error                 (err1)
  );

  // Outcome codes: 0..3 ICW1..4, 4..6 OCW1..3, 7 sequence_error, -1 none, 99 bad
  assign ev0 = {err0, ocw3_0, ocw2_0, ocw1_0, icw4_0, icw3_0, icw2_0, icw1_0};
  assign ev1 = {err1, ocw3_1, ocw2_1, ocw1_1, icw4_1, icw3_1, icw2_1, icw1_1};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       a0;
    logic [7:0] d;
    int         exp_ev0;
    int         exp_init0;
    int         exp_casc0;
    int         exp_ev1;
    int         exp_init1;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Run 16 cycles of a bus write and collect the outcome pulses of both DUTs.
  task automatic do_write(input logic use_cs, input logic a0, input logic [7:0] d,
                          output int code0, output int data0,
                          output int code1, output int data1);
    int hits0 = 0;
    int hits1 = 0;
    code0 = -1;
    code1 = -1;
    data0 = -1;
    data1 = -1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clock);
      #1;
      if (c == 0) begin
        chip_select_n  = ~use_cs;
        address        = a0;
        data_bus_in    = d;
        write_enable_n = 1'b0;
      end
      if (c == 3) write_enable_n = 1'b1;
      if (c == 5) chip_select_n = 1'b1;
      @(negedge clock);
      for (int b = 0; b < 8; b++) begin
        if (ev0[b]) begin
          hits0++;
          code0 = b;
          data0 = int'(idb0);
        end
        if (ev1[b]) begin
          hits1++;
          code1 = b;
          data1 = int'(idb1);
        end
      end
    end
    if (hits0 > 1) code0 = 99;
    if (hits1 > 1) code1 = 99;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ev0"}, int'(ev0), 0);
    chk({tag, " ev1"}, int'(ev1), 0);
    chk({tag, " idb0"}, int'(idb0), 0);
    chk({tag, " idb1"}, int'(idb1), 0);
    chk({tag, " init0"}, int'(init0), 0);
    chk({tag, " casc0"}, int'(casc0), 0);
    chk({tag, " read0"}, int'(read0), 0);
    chk({tag, " rstart0"}, int'(rstart0), 0);
  endtask

  initial begin
    int c0, d0, c1, d1;
    int rd_hi, rs_hi, wr_hits;

    //        a0    data   ev0 in0 cs0 ev1 in1
    tbl[0]  = '{1'b0, 8'h20, 7, 0, 0, 7, 0};  // OCW2 before init -> error
    tbl[1]  = '{1'b0, 8'h13, 0, 0, 0, 0, 0};
    tbl[2]  = '{1'b1, 8'h20, 1, 0, 0, 1, 0};
    tbl[3]  = '{1'b1, 8'h01, 3, 1, 0, 3, 1};
    tbl[4]  = '{1'b1, 8'hFB, 4, 1, 0, 4, 1};
    tbl[5]  = '{1'b0, 8'h20, 5, 1, 0, 5, 1};
    tbl[6]  = '{1'b0, 8'h0B, 6, 1, 0, 6, 1};
    tbl[7]  = '{1'b0, 8'h13, 0, 0, 0, 0, 0};  // restart from READY
    tbl[8]  = '{1'b0, 8'h11, 0, 0, 1, 0, 0};  // restart mid-sequence
    tbl[9]  = '{1'b1, 8'h20, 1, 0, 1, 1, 0};
    tbl[10] = '{1'b0, 8'h05, 7, 0, 1, 7, 0};  // OCW-shaped write in WAIT_ICW3/4
    tbl[11] = '{1'b1, 8'h04, 2, 0, 1, 3, 1};
    tbl[12] = '{1'b1, 8'h01, 3, 1, 1, 4, 1};

    reset_n        = 1'b0;
    chip_select_n  = 1'b1;
    read_enable_n  = 1'b1;
    write_enable_n = 1'b1;
    address        = 1'b0;
    data_bus_in    = 8'h00;
    #3;
    chk_reset_outputs("reset");
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);

    for (int i = 0; i < 13; i++) begin
      do_write(1'b1, tbl[i].a0, tbl[i].d, c0, d0, c1, d1);
      chk($sformatf("vec%0d ev0", i), c0, tbl[i].exp_ev0);
      chk($sformatf("vec%0d data0", i), d0, int'(tbl[i].d));
      chk($sformatf("vec%0d init0", i), int'(init0), tbl[i].exp_init0);
      chk($sformatf("vec%0d casc0", i), int'(casc0), tbl[i].exp_casc0);
      chk($sformatf("vec%0d ev1", i), c1, tbl[i].exp_ev1);
      chk($sformatf("vec%0d data1", i), d1, int'(tbl[i].d));
      chk($sformatf("vec%0d init1", i), int'(init1), tbl[i].exp_init1);
      chk($sformatf("vec%0d casc1", i), int'(casc1), 0);
    end

    // Write strobe with chip select idle is not an event.
    do_write(1'b0, 1'b1, 8'h77, c0, d0, c1, d1);
    chk("nocs ev0", c0, -1);
    chk("nocs ev1", c1, -1);
    chk("nocs idb0", int'(idb0), 8'h01);

    // Five-cycle read: level for five cycles, one start pulse, no write outcome.
    rd_hi   = 0;
    rs_hi   = 0;
    wr_hits = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clock);
      #1;
      if (c == 0) begin
        chip_select_n = 1'b0;
        read_enable_n = 1'b0;
      end
      if (c == 5) begin
        chip_select_n = 1'b1;
        read_enable_n = 1'b1;
      end
      @(negedge clock);
      if (read0) rd_hi++;
      if (rstart0) rs_hi++;
      if (ev0 != 8'h00) wr_hits++;
    end
    chk("read cycles", rd_hi, 5);
    chk("read_start pulses", rs_hi, 1);
    chk("read no write", wr_hits, 0);
    chk("read keeps init", int'(init0), 1);

    // Reset in the middle of a write: outputs clear at once, nothing after release.
    @(posedge clock);
    #1;
    chip_select_n  = 1'b0;
    address        = 1'b1;
    data_bus_in    = 8'hAA;
    write_enable_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    write_enable_n = 1'b1;
    chip_select_n  = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    wr_hits = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      if (ev0 != 8'h00) wr_hits++;
      if (ev1 != 8'h00) wr_hits++;
    end
    chk("post-reset strobes", wr_hits, 0);
    chk("post-reset init0", int'(init0), 0);
    chk("post-reset idb0", int'(idb0), 0);

    // A fresh ICW1 still works after that reset.
    do_write(1'b1, 1'b0, 8'h13, c0, d0, c1, d1);
    chk("after reset icw1", c0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
